// File: rtl/priority_cd_pkg.sv
// Shared constants and width helper for the registered priority encoder.
package priority_cd_pkg;

    localparam int unsigned PRIORITY_CD_IN_WIDTH_DEFAULT = 8;

    // Encoded index width for a given request width, never below one bit.
    function automatic int unsigned priority_cd_out_width(input int unsigned in_width);
        int unsigned w;
        w = $clog2(in_width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : priority_cd_pkg

// File: rtl/priority_cd_comb.sv
// Combinational priority encoder: highest-index set request wins.
// Optional one-hot grant output under PRIORITY_CD_GRANT_EN.
module priority_cd_comb
    import priority_cd_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = PRIORITY_CD_IN_WIDTH_DEFAULT,
    localparam int unsigned OUT_WIDTH = priority_cd_out_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out_next_c,
    output logic                 valid_next_c
`ifdef PRIORITY_CD_GRANT_EN
    ,
    output logic [IN_WIDTH-1:0]  grant_next_c
`endif
);

    // Ascending scan so the last hit, the highest index, overrides lower ones.
    always_comb begin
        out_next_c   = '0;
        valid_next_c = 1'b0;
`ifdef PRIORITY_CD_GRANT_EN
        grant_next_c = '0;
`endif
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (in[OUT_WIDTH'(i)]) begin
                out_next_c   = OUT_WIDTH'(i);
                valid_next_c = 1'b1;
`ifdef PRIORITY_CD_GRANT_EN
                grant_next_c                 = '0;
                grant_next_c[OUT_WIDTH'(i)]  = 1'b1;
`endif
            end
        end
    end

endmodule : priority_cd_comb

// File: rtl/priority_cd_reg.sv
// Priority encoder with one-cycle registered out/valid (and grant when
// PRIORITY_CD_GRANT_EN is defined); synchronous active-high reset.
module priority_cd_reg
    import priority_cd_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = PRIORITY_CD_IN_WIDTH_DEFAULT,
    localparam int unsigned OUT_WIDTH = priority_cd_out_width(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 valid
`ifdef PRIORITY_CD_GRANT_EN
    ,
    output logic [IN_WIDTH-1:0]  grant
`endif
);

    logic [OUT_WIDTH-1:0] out_next_c;
    logic                 valid_next_c;
    logic [OUT_WIDTH-1:0] out_d,   out_q;
    logic                 valid_d, valid_q;
`ifdef PRIORITY_CD_GRANT_EN
    logic [IN_WIDTH-1:0]  grant_next_c;
    logic [IN_WIDTH-1:0]  grant_d, grant_q;
`endif

    priority_cd_comb #(
        .IN_WIDTH     (IN_WIDTH)
    ) u_comb (
        .in           (in),
        .out_next_c   (out_next_c),
        .valid_next_c (valid_next_c)
`ifdef PRIORITY_CD_GRANT_EN
        ,
        .grant_next_c (grant_next_c)
`endif
    );

    always_comb begin
        out_d   = out_next_c;
        valid_d = valid_next_c;
`ifdef PRIORITY_CD_GRANT_EN
        grant_d = grant_next_c;
`endif
    end

    // Reset wins over the incoming result, so an in-flight value is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef PRIORITY_CD_GRANT_EN
            grant_q <= '0;
`endif
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
`ifdef PRIORITY_CD_GRANT_EN
            grant_q <= grant_d;
`endif
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
`ifdef PRIORITY_CD_GRANT_EN
    assign grant = grant_q;
`endif

endmodule : priority_cd_reg

// File: tb/tb_priority_cd_reg.sv
// Directed bench for priority_cd_reg at IN_WIDTH=8 and IN_WIDTH=5; grant
// checks are active when PRIORITY_CD_GRANT_EN is defined.
module tb_priority_cd_reg;

    logic       clk;
    logic       rst;
    logic [7:0] in8;
    logic [4:0] in5;
    logic [2:0] out8;
    logic       valid8;
    logic [2:0] out5;
    logic       valid5;
`ifdef PRIORITY_CD_GRANT_EN
    logic [7:0] grant8;
    logic [4:0] grant5;
`endif

    int n_cmp;
    int n_err;

    logic [2:0] exp_out8, exp_out5;
    logic       exp_valid8, exp_valid5;
    logic       have_prev;

    priority_cd_reg #(.IN_WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .in    (in8),
        .out   (out8),
        .valid (valid8)
`ifdef PRIORITY_CD_GRANT_EN
        ,
        .grant (grant8)
`endif
    );

    priority_cd_reg #(.IN_WIDTH(5)) dut5 (
        .clk   (clk),
        .rst   (rst),
        .in    (in5),
        .out   (out5),
        .valid (valid5)
`ifdef PRIORITY_CD_GRANT_EN
        ,
        .grant (grant5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan from the top down, first set bit is the answer.
    function automatic int msb_idx(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle; confirm outputs hold until the edge, then check result.
    task automatic step(input logic r, input logic [7:0] a, input logic [4:0] b);
        rst = r;
        in8 = a;
        in5 = b;
        #2;
        if (have_prev) begin
            check("hold_out8", 32'(out8), 32'(exp_out8));
            check("hold_valid8", 32'(valid8), 32'(exp_valid8));
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_out8 = '0; exp_valid8 = 1'b0;
            exp_out5 = '0; exp_valid5 = 1'b0;
        end else begin
            exp_out8 = 3'(msb_idx(32'(a), 8)); exp_valid8 = (a != 8'h00);
            exp_out5 = 3'(msb_idx(32'(b), 5)); exp_valid5 = (b != 5'h00);
        end
        have_prev = 1'b1;
        check("out8", 32'(out8), 32'(exp_out8));
        check("valid8", 32'(valid8), 32'(exp_valid8));
        check("out5", 32'(out5), 32'(exp_out5));
        check("valid5", 32'(valid5), 32'(exp_valid5));
        check("range5", 32'(out5 <= 3'd4), 32'd1);
`ifdef PRIORITY_CD_GRANT_EN
        check("grant8", 32'(grant8), exp_valid8 ? (32'd1 << exp_out8) : 32'd0);
        check("grant5", 32'(grant5), exp_valid5 ? (32'd1 << exp_out5) : 32'd0);
`endif
    endtask

    // Hand-computed directed vectors for the 8-bit instance.
    typedef struct {
        logic [7:0] vin;
        logic [2:0] vout;
        logic       vvalid;
        logic [7:0] vgrant;
    } vec8_t;

    vec8_t vecs[$];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        have_prev = 1'b0;
        rst       = 1'b1;
        in8       = 8'h00;
        in5       = 5'h00;

        // Reset with all requests high: outputs forced to zero.
        step(1'b1, 8'hFF, 5'h1F);
        check("rst_out", 32'(out8), 32'd0);
        check("rst_valid", 32'(valid8), 32'd0);
`ifdef PRIORITY_CD_GRANT_EN
        check("rst_grant", 32'(grant8), 32'd0);
`endif
        step(1'b0, 8'hFF, 5'h1F);
        check("post_rst_out", 32'(out8), 32'd7);
        check("post_rst_valid", 32'(valid8), 32'd1);
`ifdef PRIORITY_CD_GRANT_EN
        check("post_rst_grant", 32'(grant8), 32'h80);
`endif

        vecs.push_back('{8'h01, 3'd0, 1'b1, 8'h01});
        vecs.push_back('{8'h06, 3'd2, 1'b1, 8'h04});
        vecs.push_back('{8'h10, 3'd4, 1'b1, 8'h10});
        vecs.push_back('{8'h7F, 3'd6, 1'b1, 8'h40});
        vecs.push_back('{8'hFF, 3'd7, 1'b1, 8'h80});
        vecs.push_back('{8'h51, 3'd6, 1'b1, 8'h40});
        vecs.push_back('{8'h01, 3'd0, 1'b1, 8'h01});
        vecs.push_back('{8'h80, 3'd7, 1'b1, 8'h80});
        vecs.push_back('{8'h00, 3'd0, 1'b0, 8'h00});
        vecs.push_back('{8'h04, 3'd2, 1'b1, 8'h04});
        foreach (vecs[k]) begin
            step(1'b0, vecs[k].vin, 5'h00);
            check("dir_out", 32'(out8), 32'(vecs[k].vout));
            check("dir_valid", 32'(valid8), 32'(vecs[k].vvalid));
`ifdef PRIORITY_CD_GRANT_EN
            check("dir_grant", 32'(grant8), 32'(vecs[k].vgrant));
`endif
        end

        // Non-power-of-two instance directed points.
        step(1'b0, 8'h00, 5'b10000);
        check("w5_out_16", 32'(out5), 32'd4);
        check("w5_valid_16", 32'(valid5), 32'd1);
        step(1'b0, 8'h00, 5'b00011);
        check("w5_out_3", 32'(out5), 32'd1);
        step(1'b0, 8'h00, 5'b00000);
        check("w5_valid_0", 32'(valid5), 32'd0);

        // Full sweep with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                step(1'b1, 8'(i), 5'(i));
                check("midrst_out", 32'(out8), 32'd0);
                check("midrst_valid", 32'(valid8), 32'd0);
            end
            step(1'b0, 8'(i), 5'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_priority_cd_reg
